// File: rtl/i2s_tx.sv
// I2S transmitter: 16-bit stereo PCM in through a 1-deep valid/ready buffer, SCLK/LRCLK/SDATA out.
// Define I2S_LEFT_JUSTIFIED_EN for left-justified output (no one-bit delay, inverted word select).
module i2s_tx #(
    parameter int unsigned CLKDIV = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] left,
    input  logic [15:0] right,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic        underrun,
    output logic        i2s_sclk,
    output logic        i2s_lrclk,
    output logic        i2s_sdata
);

    localparam logic [7:0] CNT_MAX = 8'(CLKDIV - 1);
`ifdef I2S_LEFT_JUSTIFIED_EN
    localparam logic LRCLK_RST = 1'b0;
`else
    localparam logic LRCLK_RST = 1'b1;
`endif

    logic [7:0]  cnt_q, cnt_d;
    logic        sclk_q, sclk_d;
    logic [4:0]  slot_q, slot_d;
    logic        lrclk_q, lrclk_d;
    logic        sdata_q, sdata_d;
    logic        underrun_q, underrun_d;
    logic        ready_q, ready_d;
    logic        buf_full_q, buf_full_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] frame_q, frame_d;
`ifndef I2S_LEFT_JUSTIFIED_EN
    logic        lsb_q, lsb_d;
`endif
    logic        tick, fall, accept;
    logic [4:0]  bit_idx;

    always_comb begin
        cnt_d      = cnt_q + 8'd1;
        sclk_d     = sclk_q;
        slot_d     = slot_q;
        lrclk_d    = lrclk_q;
        sdata_d    = sdata_q;
        underrun_d = 1'b0;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        frame_d    = frame_q;
        bit_idx    = '0;
`ifndef I2S_LEFT_JUSTIFIED_EN
        lsb_d      = lsb_q;
`endif
        tick   = (cnt_q == CNT_MAX);
        fall   = tick && sclk_q;
        accept = sample_valid && ready_q;

        if (tick) begin
            cnt_d  = '0;
            sclk_d = ~sclk_q;
        end

        // Frame load is resolved before buffer capture so the frame always takes the old contents.
        if (fall) begin
            slot_d = slot_q + 5'd1;
            if (slot_q == 5'd31) begin
                if (buf_full_q) begin
                    frame_d    = buf_q;
                    buf_full_d = 1'b0;
                end else begin
                    underrun_d = 1'b1;
                end
`ifndef I2S_LEFT_JUSTIFIED_EN
                lsb_d = frame_q[0];
`endif
            end
`ifdef I2S_LEFT_JUSTIFIED_EN
            lrclk_d = ~slot_d[4];
            bit_idx = 5'd31 - slot_d;
            sdata_d = frame_d[bit_idx];
`else
            // 32 - s wraps to 0 at slot 0, where the saved LSB is sent instead.
            lrclk_d = slot_d[4];
            bit_idx = 5'd0 - slot_d;
            sdata_d = (slot_d == 5'd0) ? lsb_d : frame_d[bit_idx];
`endif
        end

        if (accept) begin
            buf_d      = {left, right};
            buf_full_d = 1'b1;
        end
        ready_d = ~buf_full_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            sclk_q     <= 1'b0;
            slot_q     <= 5'd31;
            lrclk_q    <= LRCLK_RST;
            sdata_q    <= 1'b0;
            underrun_q <= 1'b0;
            ready_q    <= 1'b1;
            buf_full_q <= 1'b0;
            buf_q      <= '0;
            frame_q    <= '0;
`ifndef I2S_LEFT_JUSTIFIED_EN
            lsb_q      <= 1'b0;
`endif
        end else begin
            cnt_q      <= cnt_d;
            sclk_q     <= sclk_d;
            slot_q     <= slot_d;
            lrclk_q    <= lrclk_d;
            sdata_q    <= sdata_d;
            underrun_q <= underrun_d;
            ready_q    <= ready_d;
            buf_full_q <= buf_full_d;
            buf_q      <= buf_d;
            frame_q    <= frame_d;
`ifndef I2S_LEFT_JUSTIFIED_EN
            lsb_q      <= lsb_d;
`endif
        end
    end

    assign sample_ready = ready_q;
    assign underrun     = underrun_q;
    assign i2s_sclk     = sclk_q;
    assign i2s_lrclk    = lrclk_q;
    assign i2s_sdata    = sdata_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx (CLKDIV=4): reset timing, frame bits, underrun, backpressure, mid-frame reset.
module tb_i2s_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] left, right;
    logic        sample_valid;
    logic        sample_ready, underrun, i2s_sclk, i2s_lrclk, i2s_sdata;

    int n_total = 0;
    int n_bad   = 0;
    int uf_cnt  = 0;

    // Expected words hold the 32 bits sampled on SCLK rises, slot 0 in the MSB.
`ifdef I2S_LEFT_JUSTIFIED_EN
    localparam logic [31:0] EXP_F1 = 32'hA5C30F01;
    localparam logic [31:0] EXP_F2 = 32'hA5C30F01;
    localparam logic [31:0] EXP_F3 = 32'h11112222;
    localparam logic [31:0] EXP_F4 = 32'h80017FFE;
    localparam logic [31:0] EXP_LR = 32'hFFFF0000;
    localparam logic        LR_RST = 1'b0;
`else
    localparam logic [31:0] EXP_F1 = 32'h52E18780;
    localparam logic [31:0] EXP_F2 = 32'hD2E18780;
    localparam logic [31:0] EXP_F3 = 32'h88889111;
    localparam logic [31:0] EXP_F4 = 32'h4000BFFF;
    localparam logic [31:0] EXP_LR = 32'h0000FFFF;
    localparam logic        LR_RST = 1'b1;
`endif

    i2s_tx #(.CLKDIV(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .left         (left),
        .right        (right),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .underrun     (underrun),
        .i2s_sclk     (i2s_sclk),
        .i2s_lrclk    (i2s_lrclk),
        .i2s_sdata    (i2s_sdata)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (underrun === 1'b1) uf_cnt++;
    endtask

    task automatic wait_sclk(input logic v);
        int n = 0;
        while (i2s_sclk !== v && n < 12) begin
            step();
            n++;
        end
        if (i2s_sclk !== v) check_eq("sclk_timeout", {31'd0, i2s_sclk}, {31'd0, v});
    endtask

    task automatic collect_frame(output logic [31:0] w, output logic [31:0] lr);
        w  = '0;
        lr = '0;
        for (int i = 0; i < 32; i++) begin
            wait_sclk(1'b1);
            w[31-i]  = i2s_sdata;
            lr[31-i] = i2s_lrclk;
            wait_sclk(1'b0);
        end
    endtask

    task automatic offer(input logic [15:0] l, input logic [15:0] r);
        left         = l;
        right        = r;
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
    endtask

    logic [31:0] w, lr;

    initial begin
        rst_n        = 1'b0;
        sample_valid = 1'b0;
        left         = '0;
        right        = '0;
        repeat (3) step();
        check_eq("rst_sclk",  {31'd0, i2s_sclk},     32'd0);
        check_eq("rst_lrclk", {31'd0, i2s_lrclk},    {31'd0, LR_RST});
        check_eq("rst_sdata", {31'd0, i2s_sdata},    32'd0);
        check_eq("rst_ready", {31'd0, sample_ready}, 32'd1);
        check_eq("rst_uf",    {31'd0, underrun},     32'd0);

        // Release with a sample accepted on edge 1.
        rst_n = 1'b1;
        offer(16'hA5C3, 16'h0F01);
        check_eq("ready_after_accept", {31'd0, sample_ready}, 32'd0);
        step(); step();
        check_eq("sclk_edge3", {31'd0, i2s_sclk}, 32'd0);
        step();
        check_eq("sclk_rise_edge4", {31'd0, i2s_sclk}, 32'd1);
        repeat (3) step();
        check_eq("sclk_high_edge7", {31'd0, i2s_sclk}, 32'd1);
        step();
        check_eq("sclk_fall_edge8", {31'd0, i2s_sclk}, 32'd0);
        check_eq("lrclk_edge8", {31'd0, i2s_lrclk}, {31'd0, ~LR_RST});
        check_eq("uf_first_load", {31'd0, underrun}, 32'd0);
        check_eq("ready_after_load", {31'd0, sample_ready}, 32'd1);

        uf_cnt = 0;
        collect_frame(w, lr);
        check_eq("frame1_data", w, EXP_F1);
        check_eq("frame1_lrclk", lr, EXP_LR);
        check_eq("uf_at_slot0", {31'd0, underrun}, 32'd1);
        step();
        check_eq("uf_width", uf_cnt, 32'd1);

        // Backpressure: second offer in the same frame is ignored.
        offer(16'h1111, 16'h2222);
        check_eq("ready_bp1", {31'd0, sample_ready}, 32'd0);
        offer(16'h3333, 16'h4444);
        check_eq("ready_bp2", {31'd0, sample_ready}, 32'd0);

        uf_cnt = 0;
        collect_frame(w, lr);
        check_eq("frame2_repeat", w, EXP_F2);
        check_eq("frame2_lrclk", lr, EXP_LR);
        check_eq("uf_none_f3", uf_cnt, 32'd0);
        check_eq("ready_after_f3_load", {31'd0, sample_ready}, 32'd1);

        offer(16'hFFFF, 16'hFFFF);
        collect_frame(w, lr);
        check_eq("frame3_data", w, EXP_F3);

        // Fill the buffer, then reset at slot 20 of the all-ones frame.
        offer(16'h1234, 16'h5678);
        check_eq("ready_pre_rst", {31'd0, sample_ready}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            wait_sclk(1'b1);
            wait_sclk(1'b0);
        end
        wait_sclk(1'b1);
        check_eq("slot20_sdata", {31'd0, i2s_sdata}, 32'd1);
        check_eq("slot20_lrclk", {31'd0, i2s_lrclk}, {31'd0, LR_RST});
        rst_n = 1'b0;
        step();
        check_eq("mid_rst_sclk",  {31'd0, i2s_sclk},     32'd0);
        check_eq("mid_rst_lrclk", {31'd0, i2s_lrclk},    {31'd0, LR_RST});
        check_eq("mid_rst_sdata", {31'd0, i2s_sdata},    32'd0);
        check_eq("mid_rst_ready", {31'd0, sample_ready}, 32'd1);
        step();

        rst_n = 1'b1;
        offer(16'h8001, 16'h7FFE);
        wait_sclk(1'b1);
        wait_sclk(1'b0);
        check_eq("post_rst_uf", {31'd0, underrun}, 32'd0);
        collect_frame(w, lr);
        check_eq("post_rst_frame", w, EXP_F4);
        check_eq("post_rst_lrclk", lr, EXP_LR);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
